rom_dl_writer: RTL

- Writer side of the ROM path: takes the MiSTer byte-stream download and produces the write address, data and one-hot bank strobes that load the 2764-style program ROM banks and the 82S129-style 4-bit PROM.
- Sits between the HPS download interface and the ROM arrays; the arrays keep their registered read ports.
- Paces the stream with a wait handshake, checks address continuity, and flags completion and errors.

---
 rtl/rom_dl_writer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/rom_dl_writer.sv
`default_nettype none
// ============================================================================
// Module      : rom_dl_writer
// Description : Writer side of the ROM path. Converts the MiSTer HPS
//               byte-stream download into array write cycles for N_BANKS
//               8 KB program ROM banks followed by a PROM_DEPTH-entry
//               4-bit PROM. Paces the host with ioctl_wait, checks address
//               continuity and reports completion/error status.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            system clock, rising edge
//   n_clr          synchronous active-low reset
//   ioctl_download high for the whole download
//   ioctl_wr       one-cycle byte-valid strobe
//   ioctl_addr     byte address of ioctl_dout
//   ioctl_dout     download byte
//   ioctl_wait     host must not issue ioctl_wr while high
//   wr_addr        array address (PROM uses [7:0])
//   wr_data        array data (PROM uses [3:0])
//   wr_en          write strobe, WR_PULSE cycles per byte
//   bank_sel       one-hot ROM bank enable, qualified by wr_en
//   prom_sel       PROM enable, qualified by wr_en
//   busy           download in progress
//   done           sticky, last download ended cleanly
//   err            sticky, gap/overflow/protocol error in this download
//   csum           (ROM_DL_CHECKSUM_EN only) 8-bit sum of written bytes
// Optional    : `define ROM_DL_CHECKSUM_EN adds the csum output.
// ============================================================================
module rom_dl_writer #(
    parameter int N_BANKS    = 8,
    parameter int PROM_DEPTH = 256,
    parameter int WR_PULSE   = 2
) (
    input  logic               clk,
    input  logic               n_clr,
    input  logic               ioctl_download,
    input  logic               ioctl_wr,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    output logic               ioctl_wait,
    output logic [12:0]        wr_addr,
    output logic [7:0]         wr_data,
    output logic               wr_en,
    output logic [N_BANKS-1:0] bank_sel,
    output logic               prom_sel,
    output logic               busy,
    output logic               done,
`ifdef ROM_DL_CHECKSUM_EN
    output logic [7:0]         csum,
`endif
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [25:0] c_rom_bytes = 26'(N_BANKS) << 13;
    localparam logic [25:0] c_img_end   = c_rom_bytes + 26'(PROM_DEPTH);
    localparam logic [2:0]  c_last      = 3'(WR_PULSE - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [12:0]         r_addr;
    logic [7:0]          r_data;
    logic [N_BANKS-1:0]  r_bank;
    logic                r_prom;
    logic [2:0]          r_cnt;
    logic [24:0]         r_exp;
    logic                r_drop;
    logic                r_done;
    logic                r_err;

    logic                w_accept;
    logic                w_err_set;
    logic                w_is_rom;
    logic                w_ovf;
    logic [N_BANKS-1:0]  w_bank_oh;

    assign w_is_rom = ({1'b0, ioctl_addr} <  c_rom_bytes);
    assign w_ovf    = ({1'b0, ioctl_addr} >= c_img_end);

    always_comb begin
        w_bank_oh = '0;
        for (int i = 0; i < N_BANKS; i++) begin
            w_bank_oh[i] = (ioctl_addr[16:13] == 4'(i));
        end
    end

    // Next-state and control decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ioctl_download) w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!ioctl_download) begin
                    w_state_nxt = S_FINISH;
                end else if (ioctl_wr) begin
                    if (ioctl_addr != r_exp) w_err_set = 1'b1;
                    if (w_ovf) begin
                        // Out-of-image byte is dropped without pacing the host
                        w_err_set = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // Host ignored ioctl_wait: the byte is lost
                if (ioctl_wr) w_err_set = 1'b1;
                if (r_cnt == c_last) begin
                    w_state_nxt = (r_drop || !ioctl_download) ? S_FINISH : S_ACTIVE;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef ROM_DL_CHECKSUM_EN
    logic [7:0] r_csum;
    assign csum = r_csum;
`endif

    always_ff @(posedge clk) begin
        if (!n_clr) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_bank  <= '0;
            r_prom  <= 1'b0;
            r_cnt   <= '0;
            r_exp   <= '0;
            r_drop  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef ROM_DL_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_IDLE && ioctl_download) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
                r_exp  <= '0;
                r_drop <= 1'b0;
`ifdef ROM_DL_CHECKSUM_EN
                r_csum <= '0;
`endif
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end

            if (w_state_nxt == S_FINISH && r_state != S_FINISH) begin
                r_done <= ~(r_err | w_err_set);
            end

            // Expected address always resyncs to the byte just seen
            if (r_state == S_ACTIVE && ioctl_download && ioctl_wr) begin
                r_exp <= ioctl_addr + 25'd1;
            end

            if (w_accept) begin
                r_addr <= w_is_rom ? ioctl_addr[12:0] : {5'b0, ioctl_addr[7:0]};
                r_data <= ioctl_dout;
                r_bank <= w_is_rom ? w_bank_oh : '0;
                r_prom <= ~w_is_rom;
                r_cnt  <= '0;
                r_drop <= 1'b0;
            end else if (r_state == S_WRITE) begin
                r_cnt <= r_cnt + 3'd1;
                // Remember a download end seen mid-pulse
                if (!ioctl_download) r_drop <= 1'b1;
            end

`ifdef ROM_DL_CHECKSUM_EN
            if (r_state == S_WRITE && r_cnt == 3'd0) begin
                r_csum <= r_csum + r_data;
            end
`endif
        end
    end

    assign wr_en      = (r_state == S_WRITE);
    assign ioctl_wait = (r_state == S_WRITE);
    assign wr_addr    = r_addr;
    assign wr_data    = r_prom ? {4'b0, r_data[3:0]} : r_data;
    assign bank_sel   = wr_en ? r_bank : '0;
    assign prom_sel   = wr_en & r_prom;
    assign busy       = (r_state == S_ACTIVE) || (r_state == S_WRITE);
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire
